// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register built as a two-entry skid buffer.
// Main register M drives every Out* port. Skid register S catches the one
// bundle that EX may still send in the same cycle MEM stalls.
// InReady and OutValid come straight from flops, so OutReady has no
// combinational path back to EX.
// Optional feature: define OVF_TRAP_EN to raise OvfTrap when a valid
// RegWrite bundle overflowed. The RegWrite bit is then suppressed on OutCtrl.
module ex_mem_skid_reg #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Flush,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_W-1:0]     InResult,
    input  logic                  InZero,
    input  logic                  InOverflow,
    input  logic                  InCarryOut,
    input  logic [DATA_W-1:0]     InWriteData,
    input  logic [REG_ADDR_W-1:0] InRd,
    input  logic [4:0]            InCtrl,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_W-1:0]     OutResult,
    output logic                  OutZero,
    output logic                  OutOverflow,
    output logic                  OutCarryOut,
    output logic [DATA_W-1:0]     OutWriteData,
    output logic [REG_ADDR_W-1:0] OutRd,
    output logic [4:0]            OutCtrl,
    output logic                  OvfTrap
);

    // Everything that travels from EX to MEM together. Ctrl is
    // {RegWrite, MemToReg, MemRead, MemWrite, Branch}.
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  zero;
        logic                  overflow;
        logic                  carry_out;
        logic [DATA_W-1:0]     write_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [4:0]            ctrl;
    } bundle_t;

    // Occupancy: EMPTY, ONE (only M holds data), TWO (M and S both hold data).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t m_q, m_d;
    bundle_t s_q, s_d;
    logic    in_ready_q, in_ready_d;
    logic    out_valid_q, out_valid_d;

    bundle_t in_bundle;
    logic    in_xfer;
    logic    out_xfer;
    logic    ovf_trap;

    assign in_bundle = '{
        result:     InResult,
        zero:       InZero,
        overflow:   InOverflow,
        carry_out:  InCarryOut,
        write_data: InWriteData,
        rd:         InRd,
        ctrl:       InCtrl
    };

    // A handshake only completes against the registered ready/valid flops.
    assign in_xfer  = InValid && in_ready_q;
    assign out_xfer = out_valid_q && OutReady;

    // Next occupancy state. Flush overrides any transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = TWO;
                    end else if (!in_xfer && out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Main register: gets a new bundle, gets promoted skid data, or holds.
    // On flush its ctrl is cleared so a stale write cannot leak into MEM.
    always_comb begin
        m_d = m_q;
        if (Flush) begin
            m_d.ctrl = 5'b00000;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        m_d = in_bundle;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_d = in_bundle;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        m_d = s_q;
                    end
                end
                default: begin
                    m_d = m_q;
                end
            endcase
        end
    end

    // Skid register: catches the bundle that arrives while M is stalled.
    always_comb begin
        s_d = s_q;
        if (Flush) begin
            s_d.ctrl = 5'b00000;
        end else if (state_q == ONE && in_xfer && !out_xfer) begin
            s_d = in_bundle;
        end
    end

    // Handshake outputs are decoded from the next state and then registered.
    always_comb begin
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    // State and data registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef OVF_TRAP_EN
    assign ovf_trap = out_valid_q && m_q.overflow && m_q.ctrl[4];
    assign OutCtrl  = {m_q.ctrl[4] & ~ovf_trap, m_q.ctrl[3:0]};
`else
    assign ovf_trap = 1'b0;
    assign OutCtrl  = m_q.ctrl;
`endif

    assign OvfTrap      = ovf_trap;
    assign InReady      = in_ready_q;
    assign OutValid     = out_valid_q;
    assign OutResult    = m_q.result;
    assign OutZero      = m_q.zero;
    assign OutOverflow  = m_q.overflow;
    assign OutCarryOut  = m_q.carry_out;
    assign OutWriteData = m_q.write_data;
    assign OutRd        = m_q.rd;

endmodule
